// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state type and default sizing for the alu_core slice.
package alu_pkg;

   localparam logic [2:0] OP_NOP = 3'b000;
   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_XOR = 3'b011;
   localparam logic [2:0] OP_MUL = 3'b100;

   localparam int DEF_DATA_W  = 8;
   localparam int DEF_MUL_LAT = 3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY    = 2'd1,
      RELEASE = 2'd2
   } fsm_state_t;

   function automatic logic is_illegal(input logic [2:0] op);
      return op > OP_MUL;
   endfunction

   // Edges from capture to done; only mul takes longer than one edge.
   function automatic logic [3:0] op_latency(input logic [2:0] op, input logic [3:0] mul_lat);
      return (op == OP_MUL) ? mul_lat : 4'd1;
   endfunction

endpackage

// File: rtl/alu_mul_pipe.sv
// Registered unsigned multiplier: the product of a_i*b_i appears on p_o after STAGES edges.
module alu_mul_pipe #(
   parameter int DATA_W = 8,
   parameter int STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_W-1:0]     a_i,
   input  logic [DATA_W-1:0]     b_i,
   output logic [2*DATA_W-1:0]   p_o
);

   localparam int RES_W = 2*DATA_W;

   logic [RES_W-1:0] prod_d;
   logic [RES_W-1:0] stage_q [STAGES];

   assign prod_d = RES_W'(a_i) * RES_W'(b_i);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
      end else begin
         stage_q[0] <= prod_d;
         for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   assign p_o = stage_q[STAGES-1];

endmodule

// File: rtl/alu_core.sv
// start/done ALU responder: add, and, xor, pipelined mul; one-cycle done pulse.
// Optional illegal-opcode error reporting is enabled by defining ALU_ILLEGAL_OP_ERR_EN.
module alu_core
   import alu_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int MUL_LAT = DEF_MUL_LAT
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [2:0]            op,
   input  logic [DATA_W-1:0]     A,
   input  logic [DATA_W-1:0]     B,
   output logic                  done,
   output logic [2*DATA_W-1:0]   result,
   output fsm_state_t            state_dbg
`ifdef ALU_ILLEGAL_OP_ERR_EN
   ,output logic                 err
`endif
);

   // Handshake: a command is accepted at an IDLE edge with start=1 and op!=NOP;
   // done pulses once, and start must drop before another command is accepted.

   localparam int RES_W = 2*DATA_W;

   fsm_state_t        state_q;
   logic [2:0]        op_q;
   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] b_q;
   logic [3:0]        cnt_q;
   logic [RES_W-1:0]  product;
   logic [RES_W-1:0]  result_d;

   alu_mul_pipe #(
      .DATA_W (DATA_W),
      .STAGES (MUL_LAT-1)
   ) u_mul (
      .clk   (clk),
      .rst_n (reset_n),
      .a_i   (a_q),
      .b_i   (b_q),
      .p_o   (product)
   );

   always_comb begin
      result_d = '0;
      case (op_q)
         OP_ADD:  result_d = RES_W'(a_q) + RES_W'(b_q);
         OP_AND:  result_d = RES_W'(a_q & b_q);
         OP_XOR:  result_d = RES_W'(a_q ^ b_q);
         OP_MUL:  result_d = product;
         OP_NOP:  result_d = '0;
`ifdef ALU_ILLEGAL_OP_ERR_EN
         default: result_d = '1;
`else
         default: result_d = '0;
`endif
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         op_q    <= OP_NOP;
         a_q     <= '0;
         b_q     <= '0;
         cnt_q   <= '0;
         done    <= 1'b0;
         result  <= '0;
`ifdef ALU_ILLEGAL_OP_ERR_EN
         err     <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
`ifdef ALU_ILLEGAL_OP_ERR_EN
         err  <= 1'b0;
`endif
         case (state_q)
            IDLE: begin
               if (start && op != OP_NOP) begin
                  op_q    <= op;
                  a_q     <= A;
                  b_q     <= B;
                  cnt_q   <= op_latency(op, 4'(MUL_LAT));
                  state_q <= BUSY;
               end
            end
            BUSY: begin
               cnt_q <= cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  done    <= 1'b1;
                  result  <= result_d;
`ifdef ALU_ILLEGAL_OP_ERR_EN
                  err     <= is_illegal(op_q);
`endif
                  state_q <= RELEASE;
               end
            end
            RELEASE: begin
               if (!start) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign state_dbg = state_q;

endmodule

// File: tb/tb_alu_core.sv
// Directed plus randomized bench for alu_core against a plain-arithmetic reference model.
module tb_alu_core;
   import alu_pkg::*;

   localparam int DATA_W  = 8;
   localparam int MUL_LAT = 3;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              start;
   logic [2:0]        op;
   logic [DATA_W-1:0] A;
   logic [DATA_W-1:0] B;
   logic              done;
   logic [15:0]       result;
   fsm_state_t        state_dbg;
`ifdef ALU_ILLEGAL_OP_ERR_EN
   logic              err;
`endif

   int checks = 0;
   int errors = 0;

   alu_core #(.DATA_W(DATA_W), .MUL_LAT(MUL_LAT)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .op        (op),
      .A         (A),
      .B         (B),
      .done      (done),
      .result    (result),
      .state_dbg (state_dbg)
`ifdef ALU_ILLEGAL_OP_ERR_EN
      ,.err      (err)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [15:0] ref_result(input logic [2:0] o, input int a, input int b);
      int r;
      case (o)
         3'd1: r = a + b;
         3'd2: r = a & b;
         3'd3: r = a ^ b;
         3'd4: r = a * b;
`ifdef ALU_ILLEGAL_OP_ERR_EN
         default: r = 'hFFFF;
`else
         default: r = 0;
`endif
      endcase
      return r[15:0];
   endfunction

   function automatic int ref_lat(input logic [2:0] o);
      return (o == 3'd4) ? MUL_LAT : 1;
   endfunction

   task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Drive a command on the falling edge and return just after the capture edge.
   task automatic issue(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
      @(negedge clk);
      start = 1'b1;
      op    = o;
      A     = a;
      B     = b;
      @(posedge clk);
   endtask

   task automatic wait_done(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                            input string tag);
      int n = 0;
      #1;
      op = 3'($urandom_range(0, 7));
      A  = 8'($urandom);
      B  = 8'($urandom);
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (done !== 1'b1 && n < 20);
      check(n, ref_lat(o), {tag, "_latency"});
      check(result, ref_result(o, a, b), {tag, "_result"});
`ifdef ALU_ILLEGAL_OP_ERR_EN
      check(err, (o > 3'd4) ? 1 : 0, {tag, "_err"});
`endif
      @(posedge clk);
      #1;
      check(done, 1'b0, {tag, "_done_drop"});
   endtask

   task automatic release_start();
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #1;
      check(state_dbg, IDLE, "release_idle");
   endtask

   task automatic run_cmd(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                          input string tag);
      issue(o, a, b);
      wait_done(o, a, b, tag);
      release_start();
   endtask

   initial begin
      int    hold;
      int    seen;
      logic [2:0] ro;
      logic [7:0] ra;
      logic [7:0] rb;

      reset_n = 1'b0;
      start   = 1'b0;
      op      = 3'd0;
      A       = '0;
      B       = '0;
      repeat (2) @(posedge clk);
      #1;
      check(done, 1'b0, "reset_done");
      check(result, 16'd0, "reset_result");
      check(state_dbg, IDLE, "reset_state");
      @(negedge clk);
      reset_n = 1'b1;

      run_cmd(3'd1, 8'd200, 8'd100, "add_200_100");
      check(result, 16'd300, "add_300_const");
      run_cmd(3'd4, 8'hFF, 8'hFF, "mul_ff_ff");
      check(result, 16'hFE01, "mul_fe01_const");
      run_cmd(3'd2, 8'hF0, 8'h3C, "and_f0_3c");
      run_cmd(3'd3, 8'hF0, 8'h3C, "xor_f0_3c");

      // no_op for one edge must not produce a done
      @(negedge clk);
      start = 1'b1;
      op    = 3'd0;
      @(posedge clk);
      #1;
      check(state_dbg, IDLE, "nop_state");
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #1;
      check(done, 1'b0, "nop_no_done");

      issue(3'd1, 8'd1, 8'd2);
      wait_done(3'd1, 8'd1, 8'd2, "add_1_2");
      seen = 0;
      repeat (5) begin
         @(posedge clk);
         #1;
         if (done === 1'b1 || state_dbg !== RELEASE) seen++;
      end
      check(seen, 0, "hold_start_release");
      release_start();
      run_cmd(3'd3, 8'hAA, 8'h55, "xor_aa_55");

      // reset mid-mul
      issue(3'd4, 8'd20, 8'd30);
      @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      check(done, 1'b0, "midreset_done");
      check(result, 16'd0, "midreset_result");
      check(state_dbg, IDLE, "midreset_state");
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      seen = 0;
      repeat (6) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) seen++;
      end
      check(seen, 0, "midreset_no_done");
      run_cmd(3'd1, 8'd5, 8'd5, "add_5_5");

      run_cmd(3'b110, 8'h12, 8'h34, "illegal_110");

      // start dropped while busy: op still completes, then straight to IDLE
      issue(3'd4, 8'd12, 8'd34);
      @(negedge clk);
      start = 1'b0;
      wait_done(3'd4, 8'd12, 8'd34, "mul_drop_start");
      check(state_dbg, IDLE, "drop_start_idle");

      for (int i = 0; i < 40; i++) begin
         ro = 3'($urandom_range(1, 7));
         ra = 8'($urandom);
         rb = 8'($urandom);
         issue(ro, ra, rb);
         wait_done(ro, ra, rb, $sformatf("rand%0d_op%0d", i, ro));
         hold = $urandom_range(0, 3);
         repeat (hold) @(posedge clk);
         release_start();
      end

      // reset released with start already high is a new command
      @(negedge clk);
      reset_n = 1'b0;
      start   = 1'b1;
      op      = 3'd1;
      A       = 8'd7;
      B       = 8'd9;
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      wait_done(3'd1, 8'd7, 8'd9, "start_at_reset_release");
      release_start();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
